// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak state geometry, lane type and sponge state enum
package keccak_pkg;
    localparam int LANES  = 25;
    localparam int DIM    = 5;
    localparam int LANE_W = 64;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ABSORB,
        ST_PERM,
        ST_SQUEEZE
    } sponge_state_t;
endpackage

// File: rtl/lane_cursor.sv
// rtl/lane_cursor.sv - x/y lane cursor with wrap-at-4 carry and linear index compare
module lane_cursor
    import keccak_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [4:0] cmp_idx,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       at_idx
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= 3'd0;
            y <= 3'd0;
        end else if (inc) begin
            if (x == 3'(DIM - 1)) begin
                x <= 3'd0;
                y <= y + 3'd1;
            end else begin
                x <= x + 3'd1;
            end
        end
    end

    // Linear lane index 5*y + x never exceeds 24, so 5 bits suffice.
    assign at_idx = (({2'b00, y} * 5'd5) + {2'b00, x}) == cmp_idx;
endmodule

// File: rtl/m55_sponge_ctrl.sv
// rtl/m55_sponge_ctrl.sv - sponge sequencer and m55 port mux for the Keccak permutation engine
module m55_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_final,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        perm_start,
    input  logic        perm_done,
    input  logic [2:0]  p_rx,
    input  logic [2:0]  p_ry,
    input  logic [2:0]  p_wx,
    input  logic [2:0]  p_wy,
    input  logic        p_wr,
    input  logic [63:0] p_wd,
    output logic [63:0] p_rd,
    output logic [2:0]  m_rx,
    output logic [2:0]  m_ry,
    output logic [2:0]  m_wx,
    output logic [2:0]  m_wy,
    output logic        m_wr,
    output logic [63:0] m_wd,
    input  logic [63:0] m_rd
);
    sponge_state_t state, state_nx;
    logic          final_q, final_nx;
    logic          perm_issued;
    logic          cur_clr, cur_inc, cur_hit;
    logic [4:0]    cur_cmp;
    logic [2:0]    cx, cy;

    lane_cursor u_cursor (
        .clk     (clk),
        .rst     (rst),
        .clr     (cur_clr),
        .inc     (cur_inc),
        .cmp_idx (cur_cmp),
        .x       (cx),
        .y       (cy),
        .at_idx  (cur_hit)
    );

    // perm_issued is low only on the first cycle of each PERM visit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            final_q     <= 1'b0;
            perm_issued <= 1'b0;
        end else begin
            state       <= state_nx;
            final_q     <= final_nx;
            perm_issued <= (state == ST_PERM);
        end
    end

    always_comb begin
        state_nx   = state;
        final_nx   = final_q;
        cur_clr    = 1'b0;
        cur_inc    = 1'b0;
        cur_cmp    = 5'(LANES - 1);
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = m_rd;
        perm_start = 1'b0;
        busy       = (state != ST_IDLE);
        p_rd       = m_rd;
        m_rx       = cx;
        m_ry       = cy;
        m_wx       = cx;
        m_wy       = cy;
        m_wr       = 1'b0;
        m_wd       = '0;

        case (state)
            ST_IDLE: begin
                if (init) begin
                    state_nx = ST_CLEAR;
                    cur_clr  = 1'b1;
                end
            end
            ST_CLEAR: begin
                m_wr = 1'b1;
                if (cur_hit) begin
                    state_nx = ST_ABSORB;
                    cur_clr  = 1'b1;
                end else begin
                    cur_inc = 1'b1;
                end
            end
            ST_ABSORB: begin
                cur_cmp  = 5'(RATE_LANES - 1);
                in_ready = 1'b1;
                m_wr     = in_valid;
                m_wd     = m_rd ^ in_data;
                if (in_valid) begin
                    if (cur_hit || in_final) begin
                        state_nx = ST_PERM;
                        final_nx = final_q | in_final;
                        cur_clr  = 1'b1;
                    end else begin
                        cur_inc = 1'b1;
                    end
                end
            end
            ST_PERM: begin
                m_rx       = p_rx;
                m_ry       = p_ry;
                m_wx       = p_wx;
                m_wy       = p_wy;
                m_wr       = p_wr;
                m_wd       = p_wd;
                perm_start = !perm_issued;
                if (perm_done) begin
                    state_nx = final_q ? ST_SQUEEZE : ST_ABSORB;
                    cur_clr  = 1'b1;
                end
            end
            ST_SQUEEZE: begin
                cur_cmp   = 5'(OUT_LANES - 1);
                out_valid = 1'b1;
                out_last  = cur_hit;
                if (out_ready) begin
                    if (cur_hit) begin
                        state_nx = ST_IDLE;
                        final_nx = 1'b0;
                        cur_clr  = 1'b1;
                    end else begin
                        cur_inc = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end
endmodule
